// File: rtl/spi_txn_arbiter.sv
// ---------------------------------------------------------------------------
// spi_txn_arbiter
//
// Shares one spi_master between N_REQ requesters using round-robin
// arbitration, and sequences each transaction: chip select with setup time,
// a single-cycle request pulse to the master, a wait for its ack (bounded by
// TIMEOUT), a chip-select hold time, and finally a completion pulse (with
// read data and timeout error) back to the owning requester.
//
// Ports
//   clk        clock
//   rst        asynchronous reset, active low
//   req        per-requester request level, held until done
//   req_rd     per-requester read flag (1 = read, 0 = write only)
//   req_data   per-requester write word, requester i at [32*i+31:32*i]
//   req_n      per-requester bit count, requester i at [6*i+5:6*i]
//   done       one-cycle completion pulse to the owner
//   err        one-cycle timeout pulse, coincident with done
//   rd_data    captured read word, valid while done pulses
//   cs_n       active-low chip selects, at most one bit low
//   busy       high whenever a transaction is in progress
//   m_wr_req   write request pulse to spi_master
//   m_rd_req   read request pulse to spi_master
//   m_wr_data  write word to spi_master
//   m_n        bit count to spi_master (zero-extended)
//   m_rd_data  read word from spi_master
//   m_ack      spi_master completion pulse
// ---------------------------------------------------------------------------
module spi_txn_arbiter #(
    parameter int N_REQ    = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int TIMEOUT  = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     req_rd,
    input  logic [32*N_REQ-1:0]  req_data,
    input  logic [6*N_REQ-1:0]   req_n,
    output logic [N_REQ-1:0]     done,
    output logic [N_REQ-1:0]     err,
    output logic [31:0]          rd_data,
    output logic [N_REQ-1:0]     cs_n,
    output logic                 busy,
    output logic                 m_wr_req,
    output logic                 m_rd_req,
    output logic [31:0]          m_wr_data,
    output logic [31:0]          m_n,
    input  logic [31:0]          m_rd_data,
    input  logic                 m_ack
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    state_t             state_reg,     state_next;
    logic [31:0]        cnt_reg,       cnt_next;
    logic [PTR_W-1:0]   ptr_reg,       ptr_next;
    logic [PTR_W-1:0]   owner_reg,     owner_next;
    logic               rd_flag_reg,   rd_flag_next;
    logic               abort_reg,     abort_next;
    logic [N_REQ-1:0]   cs_n_reg,      cs_n_next;
    logic [N_REQ-1:0]   done_reg,      done_next;
    logic [N_REQ-1:0]   err_reg,       err_next;
    logic [31:0]        rd_data_reg,   rd_data_next;
    logic               m_wr_req_reg,  m_wr_req_next;
    logic               m_rd_req_reg,  m_rd_req_next;
    logic [31:0]        m_wr_data_reg, m_wr_data_next;
    logic [31:0]        m_n_reg,       m_n_next;

    // -----------------------------------------------------------------------
    // Round-robin candidates: slot gi holds requester (ptr + gi) mod N_REQ,
    // so the lowest set slot is the first requester at or after ptr.
    // -----------------------------------------------------------------------
    logic [PTR_W-1:0] cand_idx [N_REQ];
    logic [N_REQ-1:0] cand_hit;
    logic             grant_any;
    logic [PTR_W-1:0] grant_idx;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rr
        logic [PTR_W:0] sum;
        assign sum          = {1'b0, ptr_reg} + (PTR_W+1)'(gi);
        assign cand_idx[gi] = (sum >= (PTR_W+1)'(N_REQ))
                              ? PTR_W'(sum - (PTR_W+1)'(N_REQ))
                              : sum[PTR_W-1:0];
        assign cand_hit[gi] = req[cand_idx[gi]];
    end

    // Walk from the far slot down so the nearest requester overrides.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (cand_hit[i]) begin
                grant_any = 1'b1;
                grant_idx = cand_idx[i];
            end
        end
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            ptr_reg       <= '0;
            owner_reg     <= '0;
            rd_flag_reg   <= 1'b0;
            abort_reg     <= 1'b0;
            cs_n_reg      <= '1;
            done_reg      <= '0;
            err_reg       <= '0;
            rd_data_reg   <= '0;
            m_wr_req_reg  <= 1'b0;
            m_rd_req_reg  <= 1'b0;
            m_wr_data_reg <= '0;
            m_n_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            ptr_reg       <= ptr_next;
            owner_reg     <= owner_next;
            rd_flag_reg   <= rd_flag_next;
            abort_reg     <= abort_next;
            cs_n_reg      <= cs_n_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
            rd_data_reg   <= rd_data_next;
            m_wr_req_reg  <= m_wr_req_next;
            m_rd_req_reg  <= m_rd_req_next;
            m_wr_data_reg <= m_wr_data_next;
            m_n_reg       <= m_n_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        ptr_next       = ptr_reg;
        owner_next     = owner_reg;
        rd_flag_next   = rd_flag_reg;
        abort_next     = abort_reg;
        cs_n_next      = cs_n_reg;
        done_next      = '0;
        err_next       = '0;
        rd_data_next   = rd_data_reg;
        m_wr_req_next  = 1'b0;
        m_rd_req_next  = 1'b0;
        m_wr_data_next = m_wr_data_reg;
        m_n_next       = m_n_reg;

        case (state_reg)
            ST_IDLE: begin
                if (grant_any) begin
                    // Everything the master needs is captured here, so the
                    // requester may change or drop its inputs afterwards.
                    owner_next     = grant_idx;
                    rd_flag_next   = req_rd[grant_idx];
                    m_wr_data_next = req_data[32*grant_idx +: 32];
                    m_n_next       = {26'd0, req_n[6*grant_idx +: 6]};
                    abort_next     = 1'b0;
                    cs_n_next      = ~(N_REQ'(1) << grant_idx);
                    cnt_next       = '0;
                    state_next     = ST_SETUP;
                end
            end

            ST_SETUP: begin
                if (cnt_reg == 32'(CS_SETUP - 1)) begin
                    cnt_next   = '0;
                    state_next = ST_START;
                end else begin
                    cnt_next = cnt_reg + 32'd1;
                end
            end

            ST_START: begin
                // Registered, so the pulse is seen during the first WAIT cycle.
                m_wr_req_next = 1'b1;
                m_rd_req_next = rd_flag_reg;
                cnt_next      = '0;
                state_next    = ST_WAIT;
            end

            ST_WAIT: begin
                // An ack on the last counted cycle still wins over the timeout.
                if (m_ack) begin
                    if (rd_flag_reg) begin
                        rd_data_next = m_rd_data;
                    end
                    cnt_next   = '0;
                    state_next = ST_HOLD;
                end else if (cnt_reg == 32'(TIMEOUT - 1)) begin
                    abort_next = 1'b1;
                    cnt_next   = '0;
                    state_next = ST_HOLD;
                end else begin
                    cnt_next = cnt_reg + 32'd1;
                end
            end

            ST_HOLD: begin
                if (cnt_reg == 32'(CS_HOLD - 1)) begin
                    cs_n_next            = '1;
                    done_next[owner_reg] = 1'b1;
                    err_next[owner_reg]  = abort_reg;
                    ptr_next             = (owner_reg == PTR_W'(N_REQ - 1))
                                           ? '0 : owner_reg + 1'b1;
                    cnt_next             = '0;
                    state_next           = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + 32'd1;
                end
            end

            default: begin
                cs_n_next  = '1;
                cnt_next   = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

    assign done      = done_reg;
    assign err       = err_reg;
    assign rd_data   = rd_data_reg;
    assign cs_n      = cs_n_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign m_wr_req  = m_wr_req_reg;
    assign m_rd_req  = m_rd_req_reg;
    assign m_wr_data = m_wr_data_reg;
    assign m_n       = m_n_reg;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// ---------------------------------------------------------------------------
// tb_spi_txn_arbiter
//
// Scoreboard bench for spi_txn_arbiter. The stimulus process computes the
// expected grant order and per-transaction results with a transaction-level
// round-robin model and pushes them into queues; a monitor pops and compares
// whenever the DUT pulses m_wr_req or done. A responder process plays the
// spi_master, acking after a per-requester delay (or never, for timeouts).
// ---------------------------------------------------------------------------
module tb_spi_txn_arbiter;

    localparam int N        = 4;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int TIMEOUT  = 16;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    req_rd;
    logic [32*N-1:0] req_data;
    logic [6*N-1:0]  req_n;
    logic [N-1:0]    done;
    logic [N-1:0]    err;
    logic [31:0]     rd_data;
    logic [N-1:0]    cs_n;
    logic            busy;
    logic            m_wr_req;
    logic            m_rd_req;
    logic [31:0]     m_wr_data;
    logic [31:0]     m_n;
    logic [31:0]     m_rd_data;
    logic            m_ack;

    spi_txn_arbiter #(
        .N_REQ   (N),
        .CS_SETUP(CS_SETUP),
        .CS_HOLD (CS_HOLD),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_rd   (req_rd),
        .req_data (req_data),
        .req_n    (req_n),
        .done     (done),
        .err      (err),
        .rd_data  (rd_data),
        .cs_n     (cs_n),
        .busy     (busy),
        .m_wr_req (m_wr_req),
        .m_rd_req (m_rd_req),
        .m_wr_data(m_wr_data),
        .m_n      (m_n),
        .m_rd_data(m_rd_data),
        .m_ack    (m_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int owner_of(input logic [N-1:0] c);
        int r = -1;
        for (int i = 0; i < N; i++) if (!c[i]) r = i;
        return r;
    endfunction

    // Per-requester transaction configuration
    logic [31:0] cfg_data  [N];
    logic [5:0]  cfg_n     [N];
    logic        cfg_rd    [N];
    int          cfg_delay [N];
    logic        cfg_to    [N];
    logic [31:0] cfg_rdw   [N];
    logic        cfg_scr   [N];
    int          cfg_cnt   [N];

    typedef struct { int idx; logic [31:0] data; logic [31:0] n; logic rd; } start_t;
    typedef struct { int idx; logic err; logic [31:0] rd_data; } done_t;
    start_t start_q[$];
    done_t  done_q[$];

    int          model_ptr = 0;
    logic [31:0] model_rd  = 32'd0;
    int          idle_tok  = 0;
    int          setup_tok = 0;

    // ---------------- spi_master responder ----------------
    initial begin
        int left;
        int owner;
        bit pend;
        int idle_seen;
        int setup_seen;
        logic [N-1:0] prev_cs;
        left = 0; owner = 0; pend = 0; idle_seen = 0; setup_seen = 0; prev_cs = '1;
        m_ack = 1'b0;
        m_rd_data = 32'd0;
        forever begin
            @(negedge clk);
            m_ack     = 1'b0;
            m_rd_data = $urandom;
            if (!rst) begin
                pend    = 0;
                prev_cs = '1;
                continue;
            end
            if (m_wr_req) begin
                owner = owner_of(cs_n);
                if (owner >= 0) begin
                    pend = !cfg_to[owner];
                    left = cfg_delay[owner];
                end
            end
            if (pend) begin
                if (left == 0) begin
                    m_ack     = 1'b1;
                    m_rd_data = cfg_rdw[owner];
                    pend      = 0;
                end else begin
                    left--;
                end
            end else if (idle_tok != idle_seen && !busy) begin
                m_ack     = 1'b1;
                idle_seen = idle_tok;
            end else if (setup_tok != setup_seen && prev_cs == '1 && cs_n != '1) begin
                m_ack      = 1'b1;
                setup_seen = setup_tok;
            end
            prev_cs = cs_n;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [N-1:0] prev_cs;
        int grant_cyc, wr_cyc, ack_cyc, o;
        bit wr_seen, ack_seen;
        start_t s;
        done_t d;
        prev_cs = '1; grant_cyc = 0; wr_cyc = 0; ack_cyc = 0; wr_seen = 0; ack_seen = 0;
        forever begin
            @(negedge clk);
            #1;
            chk("cs_at_most_one_low", 32'($countones(~cs_n) <= 1), 32'd1);
            chk("busy_vs_cs", 32'(busy), 32'(cs_n != '1));
            chk("err_without_done", 32'(err & ~done), 32'd0);
            chk("done_at_most_one", 32'($countones(done) <= 1), 32'd1);
            chk("rd_req_without_wr_req", 32'(m_rd_req & ~m_wr_req), 32'd0);
            if (!rst) begin
                wr_seen = 0; ack_seen = 0; prev_cs = cs_n;
                continue;
            end
            if (prev_cs == '1 && cs_n != '1) begin
                grant_cyc = cyc; wr_seen = 0; ack_seen = 0;
            end
            if (m_wr_req) begin
                o = owner_of(cs_n);
                if (start_q.size() == 0) begin
                    chk("unexpected_start_owner", 32'(o), 32'hFFFF_FFFF);
                end else begin
                    s = start_q.pop_front();
                    chk("start_owner", 32'(o), 32'(s.idx));
                    chk("m_wr_data", m_wr_data, s.data);
                    chk("m_n", m_n, s.n);
                    chk("m_rd_req", 32'(m_rd_req), 32'(s.rd));
                    chk("setup_latency", 32'(cyc - grant_cyc), 32'(CS_SETUP + 1));
                end
                wr_seen = 1; wr_cyc = cyc;
            end
            if (m_ack && wr_seen && !ack_seen) begin
                ack_seen = 1; ack_cyc = cyc;
            end
            if (done != '0) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    d = done_q.pop_front();
                    chk("done_vector", 32'(done), 32'(1 << d.idx));
                    chk("err_vector", 32'(err), d.err ? 32'(1 << d.idx) : 32'd0);
                    chk("rd_data", rd_data, d.rd_data);
                    if (d.err)
                        chk("timeout_latency", 32'(cyc - wr_cyc), 32'(TIMEOUT + CS_HOLD));
                    else
                        chk("ack_to_done", ack_seen ? 32'(cyc - ack_cyc) : 32'hFFFF_FFFF,
                            32'(CS_HOLD + 1));
                end
                wr_seen = 0; ack_seen = 0;
            end
            prev_cs = cs_n;
        end
    end

    // ---------------- stimulus ----------------
    task automatic rand_cfg(input int i);
        cfg_data[i]  = $urandom;
        cfg_n[i]     = 6'($urandom);
        cfg_rd[i]    = 1'($urandom_range(0, 1));
        cfg_delay[i] = $urandom_range(0, 10);
        cfg_to[i]    = ($urandom_range(0, 5) == 0);
        cfg_rdw[i]   = $urandom;
        cfg_cnt[i]   = $urandom_range(1, 2);
        cfg_scr[i]   = (cfg_cnt[i] == 1) && ($urandom_range(0, 3) == 0);
    endtask

    task automatic plain_cfg(input int i, input int delay);
        rand_cfg(i);
        cfg_delay[i] = delay;
        cfg_to[i]    = 1'b0;
        cfg_cnt[i]   = 1;
        cfg_scr[i]   = 1'b0;
    endtask

    // Requests in 'set' are raised together while the DUT is idle; each
    // requester keeps its request until it has been served cfg_cnt times.
    task automatic run_group(input logic [N-1:0] set);
        int left[N];
        int cnt_left[N];
        int remaining, txns, p, pick, served, budget, o;
        logic [N-1:0] prev_cs;
        remaining = 0;
        for (int i = 0; i < N; i++) begin
            left[i] = set[i] ? cfg_cnt[i] : 0;
            cnt_left[i] = left[i];
            remaining += left[i];
        end
        txns = remaining;
        p = model_ptr;
        while (remaining > 0) begin
            pick = -1;
            for (int k = 0; k < N; k++)
                if (pick < 0 && left[(p + k) % N] > 0) pick = (p + k) % N;
            start_q.push_back('{pick, cfg_data[pick], {26'd0, cfg_n[pick]}, cfg_rd[pick]});
            if (cfg_rd[pick] && !cfg_to[pick]) model_rd = cfg_rdw[pick];
            done_q.push_back('{pick, cfg_to[pick], model_rd});
            left[pick]--;
            remaining--;
            p = (pick + 1) % N;
        end
        model_ptr = p;

        for (int i = 0; i < N; i++) begin
            if (set[i]) begin
                req_data[32*i +: 32] = cfg_data[i];
                req_n[6*i +: 6]      = cfg_n[i];
                req_rd[i]            = cfg_rd[i];
                req[i]               = 1'b1;
            end
        end
        served = 0;
        budget = 60 * txns;
        prev_cs = cs_n;
        while (served < txns && budget > 0) begin
            @(negedge clk);
            budget--;
            if (prev_cs == '1 && cs_n != '1) begin
                o = owner_of(cs_n);
                if (o >= 0 && cfg_scr[o]) begin
                    // Latched fields must survive the requester changing its mind.
                    req_data[32*o +: 32] = ~cfg_data[o];
                    req_n[6*o +: 6]      = ~cfg_n[o];
                    req_rd[o]            = ~cfg_rd[o];
                    req[o]               = 1'b0;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (done[i]) begin
                    served++;
                    cnt_left[i]--;
                    if (cnt_left[i] <= 0) req[i] = 1'b0;
                end
            end
            prev_cs = cs_n;
        end
        chk("group_served", 32'(served), 32'(txns));
        if (served < txns) begin
            start_q.delete();
            done_q.delete();
        end
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int waited;
        rst = 1'b0; req = '0; req_rd = '0; req_data = '0; req_n = '0;
        for (int i = 0; i < N; i++) plain_cfg(i, 1);

        repeat (3) @(negedge clk);
        #1;
        chk("reset_cs_n", 32'(cs_n), 32'hF);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_rd_data", rd_data, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_m_wr_req", 32'(m_wr_req), 32'd0);
        chk("reset_m_rd_req", 32'(m_rd_req), 32'd0);
        chk("reset_m_wr_data", m_wr_data, 32'd0);
        chk("reset_m_n", m_n, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Contention: all four requesting, requester 0 wants two turns -> 0,1,2,3,0
        for (int i = 0; i < N; i++) plain_cfg(i, 10);
        cfg_cnt[0] = 2;
        run_group(4'b1111);

        // Single write
        plain_cfg(1, 4);
        cfg_data[1] = 32'hA5A5_0F0F; cfg_n[1] = 6'd16; cfg_rd[1] = 1'b0;
        run_group(4'b0010);

        // Read
        plain_cfg(2, 3);
        cfg_rd[2] = 1'b1; cfg_rdw[2] = 32'h0000_BEEF;
        run_group(4'b0100);

        // Stray ack while idle, then while in setup
        idle_tok++;
        repeat (5) @(negedge clk);
        chk("stray_idle_busy", 32'(busy), 32'd0);
        chk("stray_idle_cs_n", 32'(cs_n), 32'hF);
        setup_tok++;
        plain_cfg(3, 5);
        run_group(4'b1000);

        // Timeout on a read (rd_data must not change), then a normal transaction
        plain_cfg(0, 0);
        cfg_to[0] = 1'b1; cfg_rd[0] = 1'b1;
        run_group(4'b0001);
        plain_cfg(0, 2);
        run_group(4'b0001);

        // Reset while waiting for ack
        plain_cfg(2, 0);
        cfg_to[2] = 1'b1;
        start_q.push_back('{2, cfg_data[2], {26'd0, cfg_n[2]}, cfg_rd[2]});
        req_data[64 +: 32] = cfg_data[2];
        req_n[12 +: 6]     = cfg_n[2];
        req_rd[2]          = cfg_rd[2];
        req[2]             = 1'b1;
        waited = 0;
        while (!m_wr_req && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("t5_reached_start", 32'(m_wr_req), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_cs_n_released", 32'(cs_n), 32'hF);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_no_done", 32'(done), 32'd0);
        chk("t5_rd_data", rd_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        model_ptr = 0;
        model_rd  = 32'd0;
        repeat (TIMEOUT + 10) @(negedge clk);
        chk("t5_start_consumed", 32'(start_q.size()), 32'd0);
        // ptr must restart at 0: order 0 then 3
        plain_cfg(0, 2);
        plain_cfg(3, 2);
        run_group(4'b1001);

        // Randomized groups
        for (int g = 0; g < 30; g++) begin
            for (int i = 0; i < N; i++) rand_cfg(i);
            run_group(N'($urandom_range(1, 15)));
        end

        repeat (5) @(negedge clk);
        chk("start_q_drained", 32'(start_q.size()), 32'd0);
        chk("done_q_drained", 32'(done_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
